// File: rtl/vga_pkg.sv
// Shared VGA definitions: output modes, default 640x480 timing, colour-bar table, greyscale expansion.
// Pure declarations; no latency, no backpressure.
package vga_pkg;

  typedef enum logic [1:0] {
    MODE_FB      = 2'd0,
    MODE_BARS    = 2'd1,
    MODE_CHECKER = 2'd2,
    MODE_WHITE   = 2'd3
  } mode_e;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // {R,G,B} on/off per bar, left to right
  localparam logic [2:0] BAR_RGB [8] = '{3'b111, 3'b110, 3'b011, 3'b010,
                                         3'b101, 3'b100, 3'b001, 3'b000};

  typedef struct packed {
    logic       hsync;
    logic       vsync;
    logic       active;
    logic       frame_start;
    logic       use_fb;
    logic [2:0] pat;
  } pix_meta_t;

  // Replicates pixel bits MSB-first into a channel of ch_w bits (result right-aligned).
  function automatic logic [7:0] expand_chan(input logic [7:0] pix, input int pix_w, input int ch_w);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < ch_w) res[3'(ch_w - 1 - i)] = pix[3'(pix_w - 1 - (i % pix_w))];
    end
    return res;
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running h/v counters with raw (unaligned) sync, active and frame-start flags.
// Flags are combinational from the counters; no backpressure.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = DEF_H_ACTIVE,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_ACTIVE  = DEF_V_ACTIVE,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int H_W       = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
  parameter int V_W       = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
  input  logic           clk,
  input  logic           reset,
  output logic [H_W-1:0] h,
  output logic [V_W-1:0] v,
  output logic           hsync_raw,
  output logic           vsync_raw,
  output logic           active_raw,
  output logic           frame_start_raw,
  output logic           line_end
);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_START = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_END   = H_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_START = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_END   = V_W'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clk) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (line_end) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + 1'b1;
    end else begin
      h <= h + 1'b1;
    end
  end

  always_comb begin
    line_end        = (h == H_LAST);
    active_raw      = (h < H_ACT) && (v < V_ACT);
    frame_start_raw = (h == '0) && (v == '0);
    hsync_raw       = (h >= HS_START && h < HS_END) ? HSYNC_POL : ~HSYNC_POL;
    vsync_raw       = (v >= VS_START && v < VS_END) ? VSYNC_POL : ~VSYNC_POL;
  end

endmodule

// File: rtl/vga_scaler_controller.sv
// VGA engine: sync timing, 2^SCALE_SHIFT upscale from block RAM, four frame-locked modes; VGA_DOUBLE_BUFFER_EN adds bank_sel.
// Pins lag the counters by RAM_LATENCY+2 clocks, addr by one clock; free-running, no backpressure.
module vga_scaler_controller
  import vga_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int SCALE_SHIFT = 1,
  parameter int PIX_W       = 2,
  parameter int RAM_LATENCY = 1,
  parameter int ADDR_W      = 17,
  parameter int R_W         = 3,
  parameter int G_W         = 3,
  parameter int B_W         = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [PIX_W-1:0]  din,
  input  logic [1:0]        mode,
`ifdef VGA_DOUBLE_BUFFER_EN
  input  logic              bank_sel,
  output logic [ADDR_W:0]   addr,
`else
  output logic [ADDR_W-1:0] addr,
`endif
  output logic              hsync,
  output logic              vsync,
  output logic              active,
  output logic              frame_start,
  output logic [R_W-1:0]    R,
  output logic [G_W-1:0]    G,
  output logic [B_W-1:0]    B
);

  localparam int H_W   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP);
  localparam int V_W   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam int DLY   = RAM_LATENCY + 1;
  localparam int BAR_W = H_ACTIVE / 8;
  localparam logic [ADDR_W-1:0] FB_W   = ADDR_W'(H_ACTIVE >> SCALE_SHIFT);
  localparam logic [V_W-1:0]    V_LAST = V_W'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [V_W-1:0]    V_SUB  = V_W'((1 << SCALE_SHIFT) - 1);
  localparam pix_meta_t IDLE = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, active: 1'b0,
                                 frame_start: 1'b0, use_fb: 1'b0, pat: 3'b000};

  logic [H_W-1:0]    h;
  logic [V_W-1:0]    v;
  logic              hsync_raw, vsync_raw, active_raw, frame_start_raw, line_end;
  mode_e             mode_q, mode_cur;
  logic [2:0]        bar_idx;
  pix_meta_t         meta0;
  pix_meta_t         pipe [1:DLY];
  logic [ADDR_W-1:0] line_base, addr_q;
  logic [R_W-1:0]    r_exp;
  logic [G_W-1:0]    g_exp;
  logic [B_W-1:0]    b_exp;

  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(HSYNC_POL), .VSYNC_POL(VSYNC_POL), .H_W(H_W), .V_W(V_W)
  ) u_timing (
    .clk(clk), .reset(reset), .h(h), .v(v),
    .hsync_raw(hsync_raw), .vsync_raw(vsync_raw), .active_raw(active_raw),
    .frame_start_raw(frame_start_raw), .line_end(line_end)
  );

  // Mode is only taken at the origin so a frame never changes pattern part-way through.
  always_comb begin
    mode_cur = frame_start_raw ? mode_e'(mode) : mode_q;
    bar_idx  = '0;
    for (int k = 1; k < 8; k++) begin
      if (int'(h) >= k * BAR_W) bar_idx = 3'(k);
    end
    meta0.hsync       = hsync_raw;
    meta0.vsync       = vsync_raw;
    meta0.active      = active_raw;
    meta0.frame_start = frame_start_raw;
    meta0.use_fb      = (mode_cur == MODE_FB);
    case (mode_cur)
      MODE_BARS:    meta0.pat = BAR_RGB[bar_idx];
      MODE_CHECKER: meta0.pat = {3{h[5] ^ v[5]}};
      MODE_WHITE:   meta0.pat = 3'b111;
      default:      meta0.pat = 3'b000;
    endcase
  end

  // Address stage: line_base tracks (v>>SCALE_SHIFT)*FB_W, stepping once per scaled line.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q    <= MODE_FB;
      line_base <= '0;
      addr_q    <= '0;
      for (int k = 1; k <= DLY; k++) pipe[k] <= IDLE;
    end else begin
      mode_q <= mode_cur;
      addr_q <= active_raw ? line_base + ADDR_W'(h >> SCALE_SHIFT) : '0;
      if (line_end) begin
        if (v == V_LAST)               line_base <= '0;
        else if ((v & V_SUB) == V_SUB) line_base <= line_base + FB_W;
      end
      pipe[1] <= meta0;
      for (int k = 2; k <= DLY; k++) pipe[k] <= pipe[k-1];
    end
  end

  always_comb begin
    r_exp = R_W'(expand_chan(8'(din), PIX_W, R_W));
    g_exp = G_W'(expand_chan(8'(din), PIX_W, G_W));
    b_exp = B_W'(expand_chan(8'(din), PIX_W, B_W));
  end

  // din for the pixel in pipe[DLY] arrives in the same cycle, so colour is resolved here.
  always_ff @(posedge clk) begin
    if (reset) begin
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
      active      <= 1'b0;
      frame_start <= 1'b0;
      R           <= '0;
      G           <= '0;
      B           <= '0;
    end else begin
      hsync       <= pipe[DLY].hsync;
      vsync       <= pipe[DLY].vsync;
      active      <= pipe[DLY].active;
      frame_start <= pipe[DLY].frame_start;
      if (!pipe[DLY].active) begin
        R <= '0;
        G <= '0;
        B <= '0;
      end else if (pipe[DLY].use_fb) begin
        R <= r_exp;
        G <= g_exp;
        B <= b_exp;
      end else begin
        R <= {R_W{pipe[DLY].pat[2]}};
        G <= {G_W{pipe[DLY].pat[1]}};
        B <= {B_W{pipe[DLY].pat[0]}};
      end
    end
  end

`ifdef VGA_DOUBLE_BUFFER_EN
  logic bank_q, bank_cur, bank_msb;

  assign bank_cur = frame_start_raw ? bank_sel : bank_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_q   <= 1'b0;
      bank_msb <= 1'b0;
    end else begin
      bank_q   <= bank_cur;
      bank_msb <= bank_cur;
    end
  end

  assign addr = {bank_msb, addr_q};
`else
  assign addr = addr_q;
`endif

endmodule

// File: tb/tb_vga_scaler_controller.sv
// Randomised bench for vga_scaler_controller on a reduced 64x40 raster with a latency-3 RAM model.
module tb_vga_scaler_controller;

  localparam int HA = 64, HF = 4, HS = 8, HB = 4;
  localparam int VA = 40, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int RL = 3;
  localparam int LAT = RL + 2;
  localparam int SS = 1;
  localparam int FBW = HA >> SS;
  localparam bit HP = 1'b1;
  localparam bit VP = 1'b0;
  localparam int NCYC = 9 * FRAME;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        act;
    logic        fs;
    logic [2:0]  r;
    logic [2:0]  g;
    logic [1:0]  b;
    logic [16:0] a;
  } obs_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  din = 2'b00;
  logic [1:0]  mode = 2'b00;
  logic [16:0] addr;
  logic        hsync, vsync, active, frame_start;
  logic [2:0]  R, G;
  logic [1:0]  B;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] seed = 32'd0;
  int          fmode [16];
  logic [16:0] hist [4] = '{default: 17'd0};

  always #5 clk = ~clk;

  vga_scaler_controller #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .HSYNC_POL(HP), .VSYNC_POL(VP), .SCALE_SHIFT(SS), .PIX_W(2),
    .RAM_LATENCY(RL), .ADDR_W(17), .R_W(3), .G_W(3), .B_W(2)
  ) dut (
    .clk(clk), .reset(reset), .din(din), .mode(mode), .addr(addr),
    .hsync(hsync), .vsync(vsync), .active(active), .frame_start(frame_start),
    .R(R), .G(G), .B(B)
  );

  function automatic logic [1:0] ram_word(input logic [16:0] a);
    logic [31:0] x;
    x = {15'd0, a} ^ ({15'd0, a} >> 3) ^ seed;
    return x[1:0];
  endfunction

  // Synchronous RAM: data for an address appears RL clocks after the address is registered.
  always @(posedge clk) begin
    #1;
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = addr;
    din = ram_word(hist[RL]);
  end

  function automatic logic [7:0] grey(input logic [1:0] p, input int w);
    logic [7:0] rep;
    rep = {4{p}};
    return rep >> (8 - w);
  endfunction

  function automatic int model_addr(input int j);
    int h, v;
    h = j % HT;
    v = (j / HT) % VT;
    if (h < HA && v < VA) return (v >> SS) * FBW + (h >> SS);
    return 0;
  endfunction

  // Expected pins and addr after the k-th clock edge since the last reset edge.
  function automatic obs_t model_obs(input int k);
    obs_t o;
    int j, h, v, bar;
    logic [1:0] p;
    logic ron, gon, bon;
    o = '0;
    o.hs = ~HP;
    o.vs = ~VP;
    if (k >= 1) o.a = 17'(model_addr(k - 1));
    if (k >= LAT) begin
      j = k - LAT;
      h = j % HT;
      v = (j / HT) % VT;
      o.hs  = (h >= HA + HF && h < HA + HF + HS) ? HP : ~HP;
      o.vs  = (v >= VA + VF && v < VA + VF + VS) ? VP : ~VP;
      o.act = (h < HA) && (v < VA);
      o.fs  = (h == 0) && (v == 0);
      if (o.act) begin
        bar = h / (HA / 8);
        ron = 1'b1; gon = 1'b1; bon = 1'b1;
        case (fmode[(j / FRAME) % 16])
          0: begin
            p = ram_word(17'(model_addr(j)));
            o.r = 3'(grey(p, 3));
            o.g = 3'(grey(p, 3));
            o.b = 2'(grey(p, 2));
          end
          1: begin
            ron = ((bar / 2) % 2) == 0;
            gon = bar < 4;
            bon = (bar % 2) == 0;
          end
          2: begin
            ron = (((h / 32) + (v / 32)) % 2) == 1;
            gon = ron;
            bon = ron;
          end
          default: ;
        endcase
        if (fmode[(j / FRAME) % 16] != 0) begin
          o.r = ron ? 3'd7 : 3'd0;
          o.g = gon ? 3'd7 : 3'd0;
          o.b = bon ? 2'd3 : 2'd0;
        end
      end
    end
    return o;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  initial begin
    int k, last_fs, act_cnt, hs_run, rst1, rst2, rst_len, j;
    bit rs, hs_ok;
    obs_t got;
    k = 0; last_fs = -1; act_cnt = 0; hs_run = 0; rst_len = 0; hs_ok = 1'b0;
    for (int i = 0; i < 16; i++) fmode[i] = 0;
    seed = $urandom;
    rst1 = 4 * FRAME + int'($urandom_range(0, FRAME - 1));
    rst2 = rst1 + FRAME / 2 + int'($urandom_range(0, FRAME));

    for (int cyc = 0; cyc < NCYC && n_bad < 40; cyc++) begin
      @(posedge clk);
      rs = reset;
      k  = rs ? 0 : k + 1;
      #1;
      got = '{hs: hsync, vs: vsync, act: active, fs: frame_start, r: R, g: G, b: B, a: addr};
      check($sformatf("pins_addr k=%0d", k), 64'(got), 64'(model_obs(k)));

      if (!rs && k == LAT) check("frame_start_after_reset", 64'(frame_start), 64'd1);
      if (k == 1 + HT + 63)      check("addr_line1_end", 64'(addr), 64'd31);
      if (k == 1 + 2 * HT)       check("addr_line2_start", 64'(addr), 64'd32);
      if (k == 1 + 39 * HT + 63) check("addr_last_pixel", 64'(addr), 64'd639);
      if (k >= LAT) begin
        j = k - LAT;
        if (j % HT == 8 && (j / HT) % VT < VA && fmode[(j / FRAME) % 16] == 1)
          check("bar1_yellow", 64'({R, G, B}), 64'({3'd7, 3'd7, 2'd0}));
      end

      if (rs) begin
        last_fs = -1; hs_ok = 1'b0; hs_run = 0;
      end else begin
        if (frame_start) begin
          if (last_fs >= 0) begin
            check("frame_period", 64'(cyc - last_fs), 64'd3760);
            check("active_per_frame", 64'(act_cnt), 64'd2560);
          end
          last_fs = cyc;
          act_cnt = 0;
        end
        if (active) act_cnt++;
        if (hsync == HP) hs_run++;
        else begin
          if (hs_run > 0 && hs_ok) check("hsync_width", 64'(hs_run), 64'd8);
          if (hs_run > 0) hs_ok = 1'b1;
          hs_run = 0;
        end
      end

      if (cyc == 2) reset = 1'b0;
      else if (cyc == rst1 || cyc == rst2) begin
        reset = 1'b1;
        rst_len = int'($urandom_range(1, 3));
      end else if (rst_len > 0) begin
        rst_len--;
        if (rst_len == 0) reset = 1'b0;
      end

      if (k % FRAME == FRAME - 20)
        mode = ((k / FRAME) < 3) ? 2'((k / FRAME) + 1) : 2'($urandom_range(0, 3));
      else if ($urandom_range(0, 499) == 0)
        mode = 2'($urandom_range(0, 3));
      if (k % FRAME == 0) fmode[(k / FRAME) % 16] = int'(mode);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
